// File: rtl/nq_exec_core_pkg.sv
// Shared encodings for the nq execution core: opcodes, ALU functions,
// branch conditions, decode-word layout and sequencer states.
package nq_exec_core_pkg;

   localparam int unsigned DATA_W  = 16;
   localparam int unsigned REG_AW  = 3;
   localparam int unsigned CTRL_W  = 33;
   localparam int unsigned STATE_W = 10;

   // Opcodes (instr[15:12]); 6..15 are NOPs
   localparam logic [3:0] OP_ALU  = 4'd0;
   localparam logic [3:0] OP_ADDI = 4'd1;
   localparam logic [3:0] OP_LDL  = 4'd2;
   localparam logic [3:0] OP_LDH  = 4'd3;
   localparam logic [3:0] OP_BR   = 4'd4;
   localparam logic [3:0] OP_JR   = 4'd5;

   // ALU function codes (instr[2:0])
   localparam logic [2:0] FN_ADD = 3'd0;
   localparam logic [2:0] FN_SUB = 3'd1;
   localparam logic [2:0] FN_AND = 3'd2;
   localparam logic [2:0] FN_OR  = 3'd3;
   localparam logic [2:0] FN_XOR = 3'd4;
   localparam logic [2:0] FN_SHL = 3'd5;
   localparam logic [2:0] FN_SHR = 3'd6;
   localparam logic [2:0] FN_NOT = 3'd7;

   // Branch conditions (instr[11:9]); 5..7 never taken
   localparam logic [2:0] CC_ALWAYS = 3'd0;
   localparam logic [2:0] CC_Z      = 3'd1;
   localparam logic [2:0] CC_NZ     = 3'd2;
   localparam logic [2:0] CC_C      = 3'd3;
   localparam logic [2:0] CC_NC     = 3'd4;

   // Decode word bit positions
   localparam int unsigned CTL_OP_LSB   = 0;
   localparam int unsigned CTL_RD_LSB   = 4;
   localparam int unsigned CTL_RA_LSB   = 7;
   localparam int unsigned CTL_RB_LSB   = 10;
   localparam int unsigned CTL_FUNC_LSB = 13;
   localparam int unsigned CTL_COND_LSB = 16;
   localparam int unsigned CTL_WR_BIT   = 19;
   localparam int unsigned CTL_HB_BIT   = 20;
   localparam int unsigned CTL_LB_BIT   = 21;
   localparam int unsigned CTL_FWE_BIT  = 22;
   localparam int unsigned CTL_BR_BIT   = 23;
   localparam int unsigned CTL_JMP_BIT  = 24;
   localparam int unsigned CTL_IMM_BIT  = 25;

   // One-hot sequencer states
   typedef enum logic [STATE_W-1:0] {
      ST_FETCH  = 10'h001,
      ST_DECODE = 10'h002,
      ST_EXEC   = 10'h004,
      ST_MEM    = 10'h008,
      ST_WB     = 10'h010
   } state_t;

   // Registered decode word; field order matches the bit positions above
   typedef struct packed {
      logic [6:0] rsvd;
      logic       use_imm;
      logic       jump;
      logic       branch;
      logic       flags_we;
      logic       lb;
      logic       hb;
      logic       wr;
      logic [2:0] cond;
      logic [2:0] func;
      logic [2:0] rb;
      logic [2:0] ra;
      logic [2:0] rd;
      logic [3:0] op;
   } ctrl_t;

   // Expand a raw instruction into the decode word
   function automatic ctrl_t nq_decode(input logic [DATA_W-1:0] instr);
      ctrl_t c;
      c      = '0;
      c.op   = instr[15:12];
      c.rd   = instr[11:9];
      c.ra   = instr[8:6];
      c.rb   = instr[5:3];
      c.func = instr[2:0];
      c.cond = instr[11:9];
      case (instr[15:12])
         OP_ALU:  begin c.wr = 1'b1; c.hb = 1'b1; c.lb = 1'b1; c.flags_we = 1'b1; end
         OP_ADDI: begin c.wr = 1'b1; c.hb = 1'b1; c.lb = 1'b1; c.flags_we = 1'b1; c.use_imm = 1'b1; end
         OP_LDL:  begin c.wr = 1'b1; c.lb = 1'b1; c.use_imm = 1'b1; end
         OP_LDH:  begin c.wr = 1'b1; c.hb = 1'b1; c.use_imm = 1'b1; end
         OP_BR:   begin c.branch = 1'b1; c.use_imm = 1'b1; end
         OP_JR:   begin c.jump = 1'b1; end
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/nq_exec_core_if.sv
// Bus between the execution core and its fetch/register-file environment.
interface nq_exec_if;
   import nq_exec_core_pkg::*;

   logic                 needWait;
   logic [DATA_W-1:0]    instr_in;
   logic [DATA_W-1:0]    pc_in;

   logic                 fetch_en;
   logic                 decode_en;
   logic                 alu_en;
   logic                 mem_en;
   logic                 reg_write_en;
   logic                 incr_pc;

   logic [REG_AW-1:0]    rf_regA;
   logic [REG_AW-1:0]    rf_regB;
   logic [REG_AW-1:0]    rf_regDest;
   logic [DATA_W-1:0]    rf_dataIn;
   logic                 rf_we;
   logic                 rf_hb;
   logic                 rf_lb;
   logic [DATA_W-1:0]    rf_dataA;
   logic [DATA_W-1:0]    rf_dataB;

   logic                 setPC;
   logic [DATA_W-1:0]    setPCValue;
   logic [CTRL_W-1:0]    ctrl_out;
   logic [STATE_W-1:0]   dbg_state;
   logic [1:0]           dbg_statusreg;

   // Environment side: supplies instructions and register read data
   modport master (
      output needWait, instr_in, pc_in, rf_dataA, rf_dataB,
      input  fetch_en, decode_en, alu_en, mem_en, reg_write_en, incr_pc,
      input  rf_regA, rf_regB, rf_regDest, rf_dataIn, rf_we, rf_hb, rf_lb,
      input  setPC, setPCValue, ctrl_out, dbg_state, dbg_statusreg
   );

   // Core side
   modport slave (
      input  needWait, instr_in, pc_in, rf_dataA, rf_dataB,
      output fetch_en, decode_en, alu_en, mem_en, reg_write_en, incr_pc,
      output rf_regA, rf_regB, rf_regDest, rf_dataIn, rf_we, rf_hb, rf_lb,
      output setPC, setPCValue, ctrl_out, dbg_state, dbg_statusreg
   );
endinterface

// File: rtl/nq_exec_core_seq.sv
// Five-phase instruction sequencer with one strobe per phase.
import nq_exec_core_pkg::*;

module nq_sequencer (
   input  logic   clk,
   input  logic   rst,
   input  logic   need_wait_i,
   output state_t state_o,
   output logic   fetch_en_o,
   output logic   decode_en_o,
   output logic   alu_en_o,
   output logic   mem_en_o,
   output logic   reg_write_en_o,
   output logic   incr_pc_o
);

   state_t state_q, state_d;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_FETCH;
      else     state_q <= state_d;
   end

   // Next state and phase strobes; only FETCH honours need_wait_i
   always_comb begin
      state_d        = state_q;
      fetch_en_o     = 1'b0;
      decode_en_o    = 1'b0;
      alu_en_o       = 1'b0;
      mem_en_o       = 1'b0;
      reg_write_en_o = 1'b0;
      incr_pc_o      = 1'b0;
      case (state_q)
         ST_FETCH: begin
            fetch_en_o = 1'b1;
            if (!need_wait_i) state_d = ST_DECODE;
         end
         ST_DECODE: begin
            decode_en_o = 1'b1;
            incr_pc_o   = 1'b1;
            state_d     = ST_EXEC;
         end
         ST_EXEC: begin
            alu_en_o = 1'b1;
            state_d  = ST_MEM;
         end
         ST_MEM: begin
            mem_en_o = 1'b1;
            state_d  = ST_WB;
         end
         ST_WB: begin
            reg_write_en_o = 1'b1;
            state_d        = ST_FETCH;
         end
         default: state_d = ST_FETCH;
      endcase
   end

   assign state_o = state_q;

endmodule

// File: rtl/nq_exec_core.sv
// Execution core top: sequencer plus decode register, ALU, flags and branch unit.
import nq_exec_core_pkg::*;

module nq_exec_core (
   input logic     clk,
   input logic     rst,
   nq_exec_if.slave bus
);

   state_t            state;
   logic              decode_en;
   logic              alu_en;

   ctrl_t             ctrl_q, ctrl_d;
   logic [8:0]        imm_q, imm_d;
   logic [DATA_W-1:0] pc_q, pc_d;
   logic [1:0]        flags_q, flags_d;   // {C,Z}

   logic [DATA_W-1:0] opa, opb, imm_sext, alu_res, wr_data;
   logic [DATA_W-1:0] br_off, br_target;
   logic [DATA_W:0]   sum17;
   logic              alu_c, cond_ok, taken;

   nq_sequencer u_seq (
      .clk            (clk),
      .rst            (rst),
      .need_wait_i    (bus.needWait),
      .state_o        (state),
      .fetch_en_o     (bus.fetch_en),
      .decode_en_o    (decode_en),
      .alu_en_o       (alu_en),
      .mem_en_o       (bus.mem_en),
      .reg_write_en_o (bus.reg_write_en),
      .incr_pc_o      (bus.incr_pc)
   );

   assign ctrl_d = nq_decode(bus.instr_in);
   assign imm_d  = bus.instr_in[8:0];
   assign pc_d   = bus.pc_in;

   // Capture decode word, immediate and instruction address during DECODE
   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q <= '0;
         imm_q  <= '0;
         pc_q   <= '0;
      end else if (decode_en) begin
         ctrl_q <= ctrl_d;
         imm_q  <= imm_d;
         pc_q   <= pc_d;
      end
   end

   // ALU: result and carry/borrow/shifted-out bit
   always_comb begin
      opa      = bus.rf_dataA;
      opb      = bus.rf_dataB;
      imm_sext = {{10{imm_q[5]}}, imm_q[5:0]};
      sum17    = '0;
      alu_res  = '0;
      alu_c    = 1'b0;
      if (ctrl_q.op == OP_ADDI) begin
         sum17   = {1'b0, opa} + {1'b0, imm_sext};
         alu_res = sum17[DATA_W-1:0];
         alu_c   = sum17[DATA_W];
      end else begin
         case (ctrl_q.func)
            FN_ADD: begin
               sum17   = {1'b0, opa} + {1'b0, opb};
               alu_res = sum17[DATA_W-1:0];
               alu_c   = sum17[DATA_W];
            end
            FN_SUB: begin
               alu_res = opa - opb;
               alu_c   = (opa < opb);
            end
            FN_AND: alu_res = opa & opb;
            FN_OR:  alu_res = opa | opb;
            FN_XOR: alu_res = opa ^ opb;
            FN_SHL: begin
               alu_res = {opa[DATA_W-2:0], 1'b0};
               alu_c   = opa[DATA_W-1];
            end
            FN_SHR: begin
               alu_res = {1'b0, opa[DATA_W-1:1]};
               alu_c   = opa[0];
            end
            default: alu_res = ~opa;
         endcase
      end
   end

   // Register write data; byte loads only drive the lane they write
   always_comb begin
      case (ctrl_q.op)
         OP_ALU, OP_ADDI: wr_data = alu_res;
         OP_LDL:          wr_data = {8'h00, imm_q[7:0]};
         OP_LDH:          wr_data = {imm_q[7:0], 8'h00};
         default:         wr_data = '0;
      endcase
   end

   // Branch condition and target
   always_comb begin
      br_off    = {{6{imm_q[8]}}, imm_q, 1'b0};
      br_target = pc_q + 16'd2 + br_off;
      case (ctrl_q.cond)
         CC_ALWAYS: cond_ok = 1'b1;
         CC_Z:      cond_ok = flags_q[0];
         CC_NZ:     cond_ok = ~flags_q[0];
         CC_C:      cond_ok = flags_q[1];
         CC_NC:     cond_ok = ~flags_q[1];
         default:   cond_ok = 1'b0;
      endcase
      taken = (ctrl_q.branch & cond_ok) | ctrl_q.jump;
   end

   // Flag update on flag-writing EXEC cycles
   always_comb begin
      flags_d = flags_q;
      if (alu_en && ctrl_q.flags_we) flags_d = {alu_c, (alu_res == '0)};
   end

   // Flag register
   always_ff @(posedge clk) begin
      if (rst) flags_q <= '0;
      else     flags_q <= flags_d;
   end

   // Side effects are suppressed in a reset cycle so an aborted EXEC is inert
   assign bus.rf_we         = alu_en & ctrl_q.wr & ~rst;
   assign bus.setPC         = alu_en & taken & ~rst;
   assign bus.setPCValue    = ctrl_q.jump ? opa : br_target;
   assign bus.rf_regA       = ctrl_q.ra;
   assign bus.rf_regB       = ctrl_q.rb;
   assign bus.rf_regDest    = ctrl_q.rd;
   assign bus.rf_dataIn     = wr_data;
   assign bus.rf_hb         = ctrl_q.hb;
   assign bus.rf_lb         = ctrl_q.lb;
   assign bus.decode_en     = decode_en;
   assign bus.alu_en        = alu_en;
   assign bus.ctrl_out      = ctrl_q;
   assign bus.dbg_state     = state;
   assign bus.dbg_statusreg = flags_q;

endmodule

// File: tb/tb_nq_exec_core.sv
// Randomized self-checking bench for nq_exec_core with a register file and
// an instruction-level reference model.
module tb_nq_exec_core;

   logic clk = 1'b0;
   logic rst;
   logic rf_clear;

   nq_exec_if bus_if ();

   nq_exec_core u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   // Environment register file, written only through the core's write port
   logic [15:0] tb_rf [8];
   always @(posedge clk) begin
      if (rf_clear) begin
         for (int i = 0; i < 8; i++) tb_rf[i] <= '0;
      end else if (bus_if.rf_we) begin
         if (bus_if.rf_hb) tb_rf[bus_if.rf_regDest][15:8] <= bus_if.rf_dataIn[15:8];
         if (bus_if.rf_lb) tb_rf[bus_if.rf_regDest][7:0]  <= bus_if.rf_dataIn[7:0];
      end
   end
   assign bus_if.rf_dataA = tb_rf[bus_if.rf_regA];
   assign bus_if.rf_dataB = tb_rf[bus_if.rf_regB];

   // Reference model state
   logic [15:0] m_rf [8];
   logic        m_c, m_z;

   int checks = 0;
   int errors = 0;

   logic [15:0] last_data, last_tgt;
   logic        last_we, last_setpc, last_hb, last_lb;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Run one instruction from FETCH through WB; w = cycles of needWait in FETCH
   task automatic run_instr(input logic [15:0] instr, input logic [15:0] pc, input int w);
      int op, rd, ra, rb, fn, a, b, res, s, t;
      logic exp_we, exp_hb, exp_lb, exp_sp, nc, nz, take;
      logic [15:0] exp_data, exp_tgt, mask;
      longint exp_ctrl;

      bus_if.instr_in = instr;
      bus_if.pc_in    = pc;
      for (int i = 0; i <= w; i++) begin
         bus_if.needWait = (i < w);
         check("fetch_state", bus_if.dbg_state, 10'h001);
         check("fetch_en", bus_if.fetch_en, 1'b1);
         check("fetch_incr_pc", bus_if.incr_pc, 1'b0);
         @(negedge clk);
      end

      // DECODE
      bus_if.needWait = 1'($urandom_range(0, 1));
      check("decode_state", bus_if.dbg_state, 10'h002);
      check("decode_strobes", {bus_if.fetch_en, bus_if.decode_en, bus_if.incr_pc, bus_if.alu_en}, 4'b0110);
      @(negedge clk);

      // EXEC: evaluate the instruction from the architectural rules
      bus_if.needWait = 1'($urandom_range(0, 1));
      op = int'(instr[15:12]); rd = int'(instr[11:9]); ra = int'(instr[8:6]);
      rb = int'(instr[5:3]);   fn = int'(instr[2:0]);
      a  = int'(m_rf[ra]);     b  = int'(m_rf[rb]);
      exp_we = 1'b0; exp_hb = 1'b0; exp_lb = 1'b0; exp_sp = 1'b0;
      exp_data = '0; exp_tgt = '0; nc = m_c; nz = m_z; res = 0;
      if (op == 0) begin
         case (fn)
            0: begin res = a + b; nc = (res > 65535); end
            1: begin res = a - b; nc = (a < b); if (res < 0) res += 65536; end
            2: begin res = a & b; nc = 1'b0; end
            3: begin res = a | b; nc = 1'b0; end
            4: begin res = a ^ b; nc = 1'b0; end
            5: begin res = a * 2; nc = (a >= 32768); end
            6: begin res = a / 2; nc = ((a % 2) == 1); end
            default: begin res = 65535 - a; nc = 1'b0; end
         endcase
         res = res % 65536;
         exp_we = 1'b1; exp_hb = 1'b1; exp_lb = 1'b1;
         exp_data = 16'(res); nz = (res == 0);
      end else if (op == 1) begin
         s = int'(instr[5:0]);
         if (s >= 32) s -= 64;
         res = a + ((s + 65536) % 65536);
         nc = (res > 65535);
         res = res % 65536;
         exp_we = 1'b1; exp_hb = 1'b1; exp_lb = 1'b1;
         exp_data = 16'(res); nz = (res == 0);
      end else if (op == 2) begin
         exp_we = 1'b1; exp_lb = 1'b1;
         exp_data = 16'(int'(instr[7:0]));
      end else if (op == 3) begin
         exp_we = 1'b1; exp_hb = 1'b1;
         exp_data = 16'(int'(instr[7:0]) * 256);
      end else if (op == 4) begin
         s = int'(instr[8:0]);
         if (s >= 256) s -= 512;
         t = int'(pc) + 2 + s * 2;
         t = ((t % 65536) + 65536) % 65536;
         case (rd)
            0: take = 1'b1;
            1: take = m_z;
            2: take = !m_z;
            3: take = m_c;
            4: take = !m_c;
            default: take = 1'b0;
         endcase
         exp_sp = take; exp_tgt = 16'(t);
      end else if (op == 5) begin
         exp_sp = 1'b1; exp_tgt = 16'(a);
      end

      exp_ctrl = longint'(op) + (longint'(rd) << 4) + (longint'(ra) << 7) + (longint'(rb) << 10)
               + (longint'(fn) << 13) + (longint'(rd) << 16)
               + (longint'(op <= 3) << 19)
               + (longint'(op == 0 || op == 1 || op == 3) << 20)
               + (longint'(op <= 2) << 21)
               + (longint'(op <= 1) << 22)
               + (longint'(op == 4) << 23)
               + (longint'(op == 5) << 24)
               + (longint'(op >= 1 && op <= 4) << 25);

      check("exec_state", bus_if.dbg_state, 10'h004);
      check("exec_alu_en", bus_if.alu_en, 1'b1);
      check("ctrl_out", bus_if.ctrl_out, exp_ctrl);
      check("rf_we", bus_if.rf_we, exp_we);
      if (exp_we) begin
         mask = (exp_hb ? 16'hFF00 : 16'h0000) | (exp_lb ? 16'h00FF : 16'h0000);
         check("rf_regDest", bus_if.rf_regDest, rd);
         check("rf_dataIn", bus_if.rf_dataIn & mask, exp_data & mask);
         check("rf_hb_lb", {bus_if.rf_hb, bus_if.rf_lb}, {exp_hb, exp_lb});
      end
      check("setPC", bus_if.setPC, exp_sp);
      if (exp_sp) check("setPCValue", bus_if.setPCValue, exp_tgt);

      last_data = bus_if.rf_dataIn; last_we = bus_if.rf_we;
      last_hb = bus_if.rf_hb; last_lb = bus_if.rf_lb;
      last_setpc = bus_if.setPC; last_tgt = bus_if.setPCValue;

      if (exp_we) begin
         if (exp_hb) m_rf[rd][15:8] = exp_data[15:8];
         if (exp_lb) m_rf[rd][7:0]  = exp_data[7:0];
      end
      m_c = nc; m_z = nz;
      @(negedge clk);

      // MEM
      bus_if.needWait = 1'($urandom_range(0, 1));
      check("mem_state", bus_if.dbg_state, 10'h008);
      check("mem_strobes", {bus_if.mem_en, bus_if.rf_we, bus_if.setPC, bus_if.incr_pc}, 4'b1000);
      @(negedge clk);

      // WB
      check("wb_state", bus_if.dbg_state, 10'h010);
      check("wb_reg_write_en", bus_if.reg_write_en, 1'b1);
      @(negedge clk);

      check("flags", bus_if.dbg_statusreg, {m_c, m_z});
      if (exp_we) check("rf_value", tb_rf[rd], m_rf[rd]);
   endtask

   task automatic load_reg(input logic [2:0] r, input logic [15:0] v);
      run_instr({4'd2, r, 1'b0, v[7:0]}, 16'h0000, 0);
      run_instr({4'd3, r, 1'b0, v[15:8]}, 16'h0002, 0);
   endtask

   // Assert reset in the EXEC cycle of an instruction and check it was aborted
   task automatic reset_mid(input logic [15:0] instr, input logic [2:0] rd);
      logic [15:0] keep;
      keep = m_rf[rd];
      bus_if.instr_in = instr;
      bus_if.pc_in    = 16'h0100;
      bus_if.needWait = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_pre_state", bus_if.dbg_state, 10'h004);
      rst = 1'b1;
      #1;
      check("rst_no_we", bus_if.rf_we, 1'b0);
      check("rst_no_setpc", bus_if.setPC, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      m_c = 1'b0; m_z = 1'b0;
      check("rst_state", bus_if.dbg_state, 10'h001);
      check("rst_flags", bus_if.dbg_statusreg, 2'b00);
      check("rst_ctrl", bus_if.ctrl_out, 33'h0);
      check("rst_reg_kept", tb_rf[rd], keep);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] instr, v;
      int op, sel;

      rst = 1'b1; rf_clear = 1'b1;
      bus_if.needWait = 1'b0; bus_if.instr_in = '0; bus_if.pc_in = '0;
      for (int i = 0; i < 8; i++) m_rf[i] = '0;
      m_c = 1'b0; m_z = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_state", bus_if.dbg_state, 10'h001);
      check("reset_ctrl", bus_if.ctrl_out, 33'h0);
      check("reset_flags", bus_if.dbg_statusreg, 2'b00);
      check("reset_strobes", {bus_if.fetch_en, bus_if.decode_en, bus_if.alu_en, bus_if.mem_en,
                              bus_if.reg_write_en, bus_if.incr_pc, bus_if.rf_we, bus_if.setPC}, 8'b1000_0000);
      rst = 1'b0; rf_clear = 1'b0;

      // Byte loads, first one stalled three cycles in FETCH
      run_instr({4'd2, 3'd4, 1'b0, 8'h34}, 16'h0000, 3);
      check("ldl_lanes", {last_hb, last_lb}, 2'b01);
      run_instr({4'd3, 3'd4, 1'b0, 8'h12}, 16'h0002, 0);
      check("ldh_lanes", {last_hb, last_lb}, 2'b10);
      check("r4_value", tb_rf[4], 16'h1234);

      // Signed overflow without carry
      load_reg(3'd1, 16'h7FFF);
      load_reg(3'd2, 16'h0001);
      run_instr({4'd0, 3'd3, 3'd1, 3'd2, 3'd0}, 16'h0020, 1);
      check("add_result", last_data, 16'h8000);
      check("add_we", last_we, 1'b1);
      check("add_flags", bus_if.dbg_statusreg, 2'b00);

      // BR on Z with Z clear
      run_instr({4'd4, 3'd1, 9'h1FE}, 16'h0010, 0);
      check("br_nz_setpc", last_setpc, 1'b0);

      // Wrap to zero sets both flags
      load_reg(3'd1, 16'hFFFF);
      run_instr({4'd1, 3'd1, 3'd1, 6'd1}, 16'h0030, 0);
      check("addi_result", last_data, 16'h0000);
      check("addi_flags", bus_if.dbg_statusreg, 2'b11);

      // BR on Z with Z set
      run_instr({4'd4, 3'd1, 9'h1FE}, 16'h0010, 0);
      check("br_z_setpc", last_setpc, 1'b1);
      check("br_z_target", last_tgt, 16'h000E);

      // Aborting EXEC with reset
      reset_mid({4'd0, 3'd3, 3'd1, 3'd2, 3'd0}, 3'd3);
      reset_mid({4'd5, 3'd0, 3'd2, 6'd0}, 3'd0);

      // Randomized instruction stream
      for (int n = 0; n < 300; n++) begin
         if (n % 12 == 0) begin
            sel = $urandom_range(0, 3);
            v = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'hFFFF : (sel == 2) ? 16'h8000 : 16'($urandom());
            load_reg(3'($urandom_range(0, 7)), v);
         end
         op = $urandom_range(0, 9);
         if (op > 5) op = $urandom_range(6, 15);
         instr = 16'($urandom());
         instr[15:12] = 4'(op);
         run_instr(instr, 16'($urandom()), $urandom_range(0, 2));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
